// File: rtl/rom_bus_bridge.sv
// rom_bus_bridge
//   Slave adapter between the picorv32 native memory interface and a
//   256x32 synchronous single-port memory with a one-cycle registered read,
//   write-first behaviour and no byte enables. Reads take one memory read,
//   full-word stores one memory write, and byte/halfword stores are done as
//   a read-modify-write so that exactly one memory write happens per store.
//
// Parameters
//   ADDR_BITS  word-address width driven to the memory (MEM_WORDS = 2**ADDR_BITS)
//   BASE_ADDR  byte base of the decoded window, aligned to MEM_WORDS*4
//
// Ports
//   clk        system clock, all state on the rising edge
//   resetn     synchronous active-low reset
//   mem_valid  CPU request valid, held until mem_ready is seen
//   mem_addr   CPU byte address
//   mem_wdata  CPU write data
//   mem_wstrb  CPU byte strobes, 0 means read
//   mem_ready  registered one-cycle acknowledge
//   mem_rdata  registered read data, valid while mem_ready=1
//   sel        combinational window hit for SoC ready/rdata muxing
//   rom_wen    memory write enable
//   rom_addr   memory word address
//   rom_wdata  memory write data
//   rom_rdata  memory read data, valid the cycle after rom_addr is presented
module rom_bus_bridge #(
  parameter int          ADDR_BITS = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic                 sel,
  output logic                 rom_wen,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic [31:0]          rom_wdata,
  input  logic [31:0]          rom_rdata
);

  // Bits above the window size select the window; the rest address inside it.
  localparam logic [31:0] WIN_MASK = ~((32'd1 << (ADDR_BITS + 2)) - 32'd1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RMW_WAIT = 2'd2;
  localparam logic [1:0] ACK      = 2'd3;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           strb_q;
  logic                 accept;
  logic                 full_wr;
  logic [31:0]          merged;

  assign sel     = mem_valid && ((mem_addr & WIN_MASK) == BASE_ADDR);
  assign accept  = (state == IDLE) && sel && !mem_ready;
  assign full_wr = accept && (mem_wstrb == 4'hF);

  // Old word from the memory with the strobed bytes of the latched store
  // laid over it.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : rom_rdata[8*i +: 8];
    end
  end

  // Gating with resetn keeps a write from landing on the edge that resets
  // the bridge in the middle of a read-modify-write.
  assign rom_wen   = resetn && (full_wr || (state == RMW_WAIT));
  assign rom_addr  = (state == IDLE) ? mem_addr[ADDR_BITS+1:2] : addr_q;
  assign rom_wdata = (state == RMW_WAIT) ? merged : mem_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (accept) begin
            addr_q  <= mem_addr[ADDR_BITS+1:2];
            wdata_q <= mem_wdata;
            strb_q  <= mem_wstrb;
            if (mem_wstrb == 4'h0) begin
              state <= RD_WAIT;
            end else if (mem_wstrb == 4'hF) begin
              // The full word was written in this cycle already.
              state     <= ACK;
              mem_ready <= 1'b1;
            end else begin
              state <= RMW_WAIT;
            end
          end
        end
        RD_WAIT: begin
          mem_rdata <= rom_rdata;
          mem_ready <= 1'b1;
          state     <= ACK;
        end
        RMW_WAIT: begin
          mem_ready <= 1'b1;
          state     <= ACK;
        end
        default: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bus_bridge.sv
// tb_rom_bus_bridge
//   Self-checking bench for rom_bus_bridge with a behavioural 256x32
//   write-first synchronous memory attached to the rom_* side.
module tb_rom_bus_bridge;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        sel;
  logic        rom_wen;
  logic [7:0]  rom_addr;
  logic [31:0] rom_wdata;
  logic [31:0] rom_rdata;

  logic [31:0] mem [256];
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          exp_lat;
    int          exp_wen;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_rom_addr;
  } vec_t;

  vec_t vecs [11];
  vec_t b2b  [3];

  rom_bus_bridge #(
    .ADDR_BITS(8),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .sel      (sel),
    .rom_wen  (rom_wen),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata),
    .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first memory: on a write the read port returns the new word.
  always @(posedge clk) begin
    if (rom_wen) begin
      mem[rom_addr] <= rom_wdata;
      rom_rdata     <= rom_wdata;
    end else begin
      rom_rdata <= mem[rom_addr];
    end
  end

  // Free-running cycle counter used to measure spacing between acknowledges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one request and watches it until mem_ready. k=0 is the accept
  // cycle, so the returned latency is the number of cycles from accept to
  // the acknowledge. A timeout returns latency -1.
  task automatic doTxn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       output int lat, output logic [31:0] rdata, output int wen_cnt,
                       output logic [31:0] wdata_seen, output logic [7:0] ra_seen,
                       output logic sel_seen, output int ready_cyc);
    mem_valid  = 1'b1;
    mem_addr   = addr;
    mem_wdata  = wdata;
    mem_wstrb  = wstrb;
    lat        = -1;
    rdata      = '0;
    wen_cnt    = 0;
    wdata_seen = '0;
    ra_seen    = '0;
    sel_seen   = 1'b0;
    ready_cyc  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ra_seen  = rom_addr;
        sel_seen = sel;
      end
      if (mem_ready) begin
        lat       = k;
        rdata     = mem_rdata;
        ready_cyc = cyc;
        break;
      end
      if (rom_wen) begin
        wen_cnt++;
        wdata_seen = rom_wdata;
      end
    end
  endtask

  // Runs one vector and compares everything it observed. With b2b set the
  // request is driven straight out of the previous acknowledge cycle.
  task automatic applyStimulus(input vec_t v, input bit b2b_mode, output int ready_cyc);
    int          lat;
    int          wen_cnt;
    logic [31:0] rdata;
    logic [31:0] wdata_seen;
    logic [7:0]  ra_seen;
    logic        sel_seen;
    if (!b2b_mode) begin
      @(posedge clk);
      #1;
    end
    doTxn(v.addr, v.wdata, v.wstrb, lat, rdata, wen_cnt, wdata_seen, ra_seen, sel_seen, ready_cyc);
    checkOutput({v.name, "_latency"}, lat, v.exp_lat);
    checkOutput({v.name, "_sel"}, {31'd0, sel_seen}, 32'd1);
    checkOutput({v.name, "_rom_addr"}, {24'd0, ra_seen}, {24'd0, v.exp_rom_addr});
    checkOutput({v.name, "_wen_pulses"}, wen_cnt, v.exp_wen);
    if (v.exp_wen != 0) checkOutput({v.name, "_rom_wdata"}, wdata_seen, v.exp_wdata);
    checkOutput({v.name, "_rdata"}, rdata, v.exp_rdata);
  endtask

  task automatic idleBus();
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  initial begin
    int rc;
    int rc_prev;
    int bad;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0013;

    vecs[0]  = '{"fw_10",      32'h010, 32'hAABBCCDD, 4'hF, 1, 1, 32'hAABBCCDD, 32'h0,        8'd4};
    vecs[1]  = '{"rd_10",      32'h010, 32'h0,        4'h0, 2, 0, 32'h0,        32'hAABBCCDD, 8'd4};
    vecs[2]  = '{"pw_10_0010", 32'h010, 32'h11223344, 4'h2, 2, 1, 32'hAABB33DD, 32'hAABBCCDD, 8'd4};
    vecs[3]  = '{"rd_10_b",    32'h010, 32'h0,        4'h0, 2, 0, 32'h0,        32'hAABB33DD, 8'd4};
    vecs[4]  = '{"pw_10_1100", 32'h010, 32'h11223344, 4'hC, 2, 1, 32'h112233DD, 32'hAABB33DD, 8'd4};
    vecs[5]  = '{"rd_10_c",    32'h010, 32'h0,        4'h0, 2, 0, 32'h0,        32'h112233DD, 8'd4};
    vecs[6]  = '{"fw_3fc",     32'h3FC, 32'hDEADBEEF, 4'hF, 1, 1, 32'hDEADBEEF, 32'h112233DD, 8'd255};
    vecs[7]  = '{"rd_000",     32'h000, 32'h0,        4'h0, 2, 0, 32'h0,        32'h00000013, 8'd0};
    vecs[8]  = '{"rd_3fc",     32'h3FC, 32'h0,        4'h0, 2, 0, 32'h0,        32'hDEADBEEF, 8'd255};
    vecs[9]  = '{"rd_3ff",     32'h3FF, 32'h0,        4'h0, 2, 0, 32'h0,        32'hDEADBEEF, 8'd255};
    vecs[10] = '{"rd_013",     32'h013, 32'h0,        4'h0, 2, 0, 32'h0,        32'h112233DD, 8'd4};

    b2b[0] = '{"b2b_rd_10", 32'h010, 32'h0,        4'h0, 2, 0, 32'h0,        32'h112233DD, 8'd4};
    b2b[1] = '{"b2b_fw_20", 32'h020, 32'h55667788, 4'hF, 1, 1, 32'h55667788, 32'h112233DD, 8'd8};
    b2b[2] = '{"b2b_rd_20", 32'h020, 32'h0,        4'h0, 2, 0, 32'h0,        32'h55667788, 8'd8};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("reset_rdata", mem_rdata, 32'd0);
    checkOutput("reset_wen", {31'd0, rom_wen}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b0, rc);
      idleBus();
    end

    // Request just above the window must be ignored entirely.
    @(posedge clk);
    #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0400;
    mem_wstrb = 4'h0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sel || mem_ready || rom_wen) bad++;
    end
    checkOutput("oow_activity", bad, 0);
    checkOutput("oow_rdata_kept", mem_rdata, 32'h112233DD);
    idleBus();

    // Back-to-back read, full write, read with valid re-asserted at once.
    applyStimulus(b2b[0], 1'b0, rc_prev);
    applyStimulus(b2b[1], 1'b1, rc);
    checkOutput("b2b_gap_rd_to_wr", rc - rc_prev, 2);
    rc_prev = rc;
    applyStimulus(b2b[2], 1'b1, rc);
    checkOutput("b2b_gap_wr_to_rd", rc - rc_prev, 3);
    idleBus();

    // Reset lands in the read-modify-write cycle of a byte store.
    @(posedge clk);
    #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0010;
    mem_wdata = 32'h0000_00FF;
    mem_wstrb = 4'h1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    idleBus();
    @(negedge clk);
    checkOutput("rst_rmw_wen", {31'd0, rom_wen}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_rmw_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("rst_rmw_rdata", mem_rdata, 32'd0);
    checkOutput("rst_rmw_mem", mem[4], 32'h112233DD);
    resetn = 1'b1;
    applyStimulus('{"rst_readback", 32'h010, 32'h0, 4'h0, 2, 0, 32'h0, 32'h112233DD, 8'd4}, 1'b0, rc);
    idleBus();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
